// File: rtl/rst_release_sequencer_pkg.sv
// Shared types and defaults for the staggered reset-release sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    SYNC,
    RELEASE,
    RUN,
    CLR_HOLD,
    CLR_RELEASE,
    WAIT_DROP
  } rst_seq_state_e;

  localparam int DEF_NUM_DOMAINS = 2;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_RELEASE_GAP = 4;
  localparam int DEF_CLEAR_PULSE = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_n_synchronizer.sv
// Active-low reset synchronizer: asserts asynchronously, deasserts after SYNC_STAGES clk edges.
module rst_n_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_rst_n
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_rst_n = chain[SYNC_STAGES-1];

endmodule

// File: rtl/rst_release_sequencer.sv
// Per-domain reset generator with staggered synchronous release and a software clear
// that re-resets every domain except the core domain 0.
module rst_release_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int RELEASE_GAP = DEF_RELEASE_GAP,
  parameter int CLEAR_PULSE = DEF_CLEAR_PULSE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_req,
  output logic                   clr_ack,
  output logic [NUM_DOMAINS-1:0] dom_rst_n,
  output logic                   all_released,
  output logic                   busy,
  output rst_seq_state_e         dbg_state
);

  localparam int CW = $clog2(max_int(RELEASE_GAP, CLEAR_PULSE) + 1);
  localparam int IW = $clog2(NUM_DOMAINS);
  localparam logic [CW-1:0] GAP_LOAD = CW'(RELEASE_GAP);
  localparam logic [CW-1:0] CLR_LOAD = CW'(CLEAR_PULSE);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DOMAINS - 1);

  if (NUM_DOMAINS < 2) begin : g_bad_num_domains
    $error("NUM_DOMAINS must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be >= 2");
  end
  if (RELEASE_GAP < 1) begin : g_bad_release_gap
    $error("RELEASE_GAP must be >= 1");
  end
  if (CLEAR_PULSE < 1) begin : g_bad_clear_pulse
    $error("CLEAR_PULSE must be >= 1");
  end

  rst_seq_state_e  state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic            sync_rst_n;

  rst_n_synchronizer #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync_rst_n(sync_rst_n)
  );

  // clr_req/clr_ack form a four-phase handshake: a request is taken only in RUN,
  // clr_ack pulses once when every cleared domain is released again, and the
  // requester must drop clr_req before another request is accepted.
  // cnt counts down from its load value; the release/expiry edge is the one
  // that samples cnt == 1, so a load of N spaces events exactly N edges apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SYNC;
      cnt          <= '0;
      idx          <= '0;
      dom_rst_n    <= '0;
      clr_ack      <= 1'b0;
      all_released <= 1'b0;
      busy         <= 1'b1;
    end else begin
      clr_ack <= 1'b0;
      case (state)
        SYNC: begin
          if (sync_rst_n) begin
            dom_rst_n[0] <= 1'b1;
            idx          <= IDX_ONE;
            cnt          <= GAP_LOAD;
            state        <= RELEASE;
          end
        end
        RELEASE, CLR_RELEASE: begin
          if (cnt == CNT_ONE) begin
            dom_rst_n[idx] <= 1'b1;
            if (idx == LAST_IDX) begin
              all_released <= 1'b1;
              busy         <= 1'b0;
              clr_ack      <= (state == CLR_RELEASE);
              state        <= (state == RELEASE) ? RUN : WAIT_DROP;
            end else begin
              idx <= idx + IDX_ONE;
              cnt <= GAP_LOAD;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        RUN: begin
          if (clr_req) begin
            dom_rst_n    <= {{(NUM_DOMAINS-1){1'b0}}, 1'b1};
            all_released <= 1'b0;
            busy         <= 1'b1;
            cnt          <= CLR_LOAD;
            state        <= CLR_HOLD;
          end
        end
        CLR_HOLD: begin
          // Domain 1 is released on the hold-expiry edge itself.
          if (cnt == CNT_ONE) begin
            dom_rst_n[1] <= 1'b1;
            if (LAST_IDX == IDX_ONE) begin
              all_released <= 1'b1;
              busy         <= 1'b0;
              clr_ack      <= 1'b1;
              state        <= WAIT_DROP;
            end else begin
              idx   <= IDX_ONE + IDX_ONE;
              cnt   <= GAP_LOAD;
              state <= CLR_RELEASE;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        WAIT_DROP: begin
          if (!clr_req) begin
            state <= RUN;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_rst_release_sequencer.sv
// Directed bench for rst_release_sequencer: default, four-domain and minimum-timing instances.
module tb_rst_release_sequencer;
  import rst_seq_pkg::*;

  logic clk;
  logic rst_n;
  logic clr_def, clr_four, clr_edge;

  logic [1:0] dom_def;
  logic       ack_def, ar_def, busy_def;
  rst_seq_state_e st_def;

  logic [3:0] dom_four;
  logic       ack_four, ar_four, busy_four;
  rst_seq_state_e st_four;

  logic [1:0] dom_edge;
  logic       ack_edge, ar_edge, busy_edge;
  rst_seq_state_e st_edge;

  int checks = 0;
  int errors = 0;

  rst_release_sequencer u_def (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_def), .clr_ack(ack_def),
    .dom_rst_n(dom_def), .all_released(ar_def), .busy(busy_def), .dbg_state(st_def)
  );

  rst_release_sequencer #(.NUM_DOMAINS(4), .RELEASE_GAP(1)) u_four (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_four), .clr_ack(ack_four),
    .dom_rst_n(dom_four), .all_released(ar_four), .busy(busy_four), .dbg_state(st_four)
  );

  rst_release_sequencer #(.RELEASE_GAP(1), .CLEAR_PULSE(1)) u_edge (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_edge), .clr_ack(ack_edge),
    .dom_rst_n(dom_edge), .all_released(ar_edge), .busy(busy_edge), .dbg_state(st_edge)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clr_def = 1'b0; clr_four = 1'b0; clr_edge = 1'b0;
    step(3);
    checks++;
    if ({dom_def, ack_def, ar_def, busy_def} !== 5'b00_0_0_1) begin
      errors++; $display("FAIL reset_def: got %b expected %b", {dom_def, ack_def, ar_def, busy_def}, 5'b00001);
    end
    checks++;
    if ({dom_four, ack_four, ar_four, busy_four} !== 7'b0000_0_0_1) begin
      errors++; $display("FAIL reset_four: got %b expected %b", {dom_four, ack_four, ar_four, busy_four}, 7'b0000001);
    end
    checks++;
    if (st_def !== SYNC || st_edge !== SYNC) begin
      errors++; $display("FAIL reset_state: got %0d/%0d expected %0d", st_def, st_edge, SYNC);
    end
  endtask

  task automatic test_power_on;
    logic [4:0] exp_def;
    logic [6:0] exp_four;
    rst_n = 1'b1;
    step(1);  // just after T0
    for (int k = 1; k <= 6; k++) begin
      step(1);  // just after T0+k
      exp_def  = (k >= 6) ? 5'b11_0_1_0 : (k >= 2) ? 5'b01_0_0_1 : 5'b00_0_0_1;
      exp_four = (k >= 5) ? 7'b1111_0_1_0 : (k == 4) ? 7'b0111_0_0_1 :
                 (k == 3) ? 7'b0011_0_0_1 : (k == 2) ? 7'b0001_0_0_1 : 7'b0000_0_0_1;
      checks++;
      if ({dom_def, ack_def, ar_def, busy_def} !== exp_def) begin
        errors++; $display("FAIL power_on_def T0+%0d: got %b expected %b", k, {dom_def, ack_def, ar_def, busy_def}, exp_def);
      end
      checks++;
      if ({dom_four, ack_four, ar_four, busy_four} !== exp_four) begin
        errors++; $display("FAIL power_on_four T0+%0d: got %b expected %b", k, {dom_four, ack_four, ar_four, busy_four}, exp_four);
      end
      if (k == 3) begin
        checks++;
        if ({dom_edge, ack_edge, ar_edge, busy_edge} !== 5'b11_0_1_0) begin
          errors++; $display("FAIL power_on_edge: got %b expected %b", {dom_edge, ack_edge, ar_edge, busy_edge}, 5'b11010);
        end
      end
    end
    checks++;
    if (st_def !== RUN) begin
      errors++; $display("FAIL power_on_state: got %0d expected %0d", st_def, RUN);
    end
  endtask

  task automatic test_clear;
    logic [4:0] exp_def;
    for (int pass = 0; pass < 2; pass++) begin
      clr_def = 1'b1;
      for (int k = 0; k <= 9; k++) begin
        step(1);  // just after C+k
        exp_def = (k == 8) ? 5'b11_1_1_0 : (k == 9) ? 5'b11_0_1_0 : 5'b01_0_0_1;
        checks++;
        if ({dom_def, ack_def, ar_def, busy_def} !== exp_def) begin
          errors++; $display("FAIL clear%0d C+%0d: got %b expected %b", pass, k, {dom_def, ack_def, ar_def, busy_def}, exp_def);
        end
      end
      step(3);
      checks++;
      if (st_def !== WAIT_DROP || ack_def !== 1'b0) begin
        errors++; $display("FAIL clear%0d_wait_drop: got state %0d ack %b expected %0d ack 0", pass, st_def, ack_def, WAIT_DROP);
      end
      clr_def = 1'b0;
      step(1);
      checks++;
      if (st_def !== RUN || dom_def !== 2'b11) begin
        errors++; $display("FAIL clear%0d_drop: got state %0d dom %b expected %0d dom 11", pass, st_def, dom_def, RUN);
      end
    end
  endtask

  task automatic test_four_clear;
    logic [6:0] exp_four;
    clr_four = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      step(1);
      exp_four = (k == 11) ? 7'b1111_0_1_0 : (k == 10) ? 7'b1111_1_1_0 :
                 (k == 9) ? 7'b0111_0_0_1 : (k == 8) ? 7'b0011_0_0_1 : 7'b0001_0_0_1;
      checks++;
      if ({dom_four, ack_four, ar_four, busy_four} !== exp_four) begin
        errors++; $display("FAIL four_clear C+%0d: got %b expected %b", k, {dom_four, ack_four, ar_four, busy_four}, exp_four);
      end
    end
    clr_four = 1'b0;
    step(1);
    checks++;
    if (st_four !== RUN) begin
      errors++; $display("FAIL four_clear_drop: got %0d expected %0d", st_four, RUN);
    end
  endtask

  task automatic test_edge_params;
    logic [4:0] exp_edge;
    clr_edge = 1'b1;
    for (int k = 0; k <= 2; k++) begin
      step(1);
      exp_edge = (k == 0) ? 5'b01_0_0_1 : (k == 1) ? 5'b11_1_1_0 : 5'b11_0_1_0;
      checks++;
      if ({dom_edge, ack_edge, ar_edge, busy_edge} !== exp_edge) begin
        errors++; $display("FAIL edge_clear C+%0d: got %b expected %b", k, {dom_edge, ack_edge, ar_edge, busy_edge}, exp_edge);
      end
    end
    clr_edge = 1'b0;
    step(1);
    checks++;
    if (st_edge !== RUN) begin
      errors++; $display("FAIL edge_drop: got %0d expected %0d", st_edge, RUN);
    end
  endtask

  task automatic test_reset_mid_clear;
    logic [4:0] exp_def;
    int acks;
    clr_def = 1'b1;
    step(3);  // just after C+2
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({dom_def, ack_def, ar_def, busy_def} !== 5'b00_0_0_1) begin
      errors++; $display("FAIL mid_clear_async: got %b expected %b", {dom_def, ack_def, ar_def, busy_def}, 5'b00001);
    end
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      if (ack_def) acks++;
    end
    rst_n = 1'b1;
    step(1);  // just after T0
    for (int k = 1; k <= 6; k++) begin
      step(1);
      if (ack_def) acks++;
      exp_def = (k >= 6) ? 5'b11_0_1_0 : (k >= 2) ? 5'b01_0_0_1 : 5'b00_0_0_1;
      checks++;
      if ({dom_def, ack_def, ar_def, busy_def} !== exp_def) begin
        errors++; $display("FAIL mid_clear_restart T0+%0d: got %b expected %b", k, {dom_def, ack_def, ar_def, busy_def}, exp_def);
      end
    end
    checks++;
    if (acks !== 0) begin
      errors++; $display("FAIL mid_clear_no_ack: got %0d ack cycles expected 0", acks);
    end
    step(1);  // first RUN edge serves the held request
    checks++;
    if (st_def !== CLR_HOLD || {dom_def, busy_def} !== 3'b01_1) begin
      errors++; $display("FAIL mid_clear_rerequest: got state %0d dom %b busy %b expected %0d 01 1", st_def, dom_def, busy_def, CLR_HOLD);
    end
    step(8);
    checks++;
    if ({dom_def, ack_def, ar_def, busy_def} !== 5'b11_1_1_0) begin
      errors++; $display("FAIL mid_clear_second_ack: got %b expected %b", {dom_def, ack_def, ar_def, busy_def}, 5'b11110);
    end
    clr_def = 1'b0;
    step(1);
    checks++;
    if (st_def !== RUN) begin
      errors++; $display("FAIL mid_clear_drop: got %0d expected %0d", st_def, RUN);
    end
  endtask

  task automatic test_glitch;
    logic [1:0] exp_dom;
    step(6);  // let every instance settle in RUN
    @(posedge clk);
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    #1;
    checks++;
    if ({dom_def, ack_def, ar_def, busy_def} !== 5'b00_0_0_1 || st_def !== SYNC) begin
      errors++; $display("FAIL glitch_async: got %b state %0d expected %b state %0d", {dom_def, ack_def, ar_def, busy_def}, st_def, 5'b00001, SYNC);
    end
    checks++;
    if (dom_four !== 4'b0000 || dom_edge !== 2'b00) begin
      errors++; $display("FAIL glitch_others: got %b/%b expected 0000/00", dom_four, dom_edge);
    end
    for (int k = 0; k <= 6; k++) begin
      step(1);  // just after T0+k
      exp_dom = (k >= 6) ? 2'b11 : (k >= 2) ? 2'b01 : 2'b00;
      checks++;
      if (dom_def !== exp_dom) begin
        errors++; $display("FAIL glitch_restart T0+%0d: got %b expected %b", k, dom_def, exp_dom);
      end
    end
    checks++;
    if (st_def !== RUN || ar_def !== 1'b1 || busy_def !== 1'b0) begin
      errors++; $display("FAIL glitch_run: got state %0d ar %b busy %b expected %0d 1 0", st_def, ar_def, busy_def, RUN);
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_clear();
    test_four_clear();
    test_edge_params();
    test_reset_mid_clear();
    test_glitch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
